// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU I/O sequencer: mode and output-FSM
// encodings, word geometry and a big-endian byte selector.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        O_IDLE  = 2'd0,
        O_SEND  = 2'd1,
        O_GUARD = 2'd2
    } out_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

    // Byte 0 is the most significant byte of the word.
    function automatic logic [7:0] word_byte(input logic [31:0]           word,
                                             input logic [BYTE_IDX_W-1:0] idx);
        logic [31:0] shifted;
        shifted = word << {idx, 3'b000};
        return shifted[31:24];
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects four bytes MSB first into a 32-bit word; word_done/word are valid
// combinationally in the cycle the fourth byte arrives.
module word_assembler
    import cpu_pkg::*;
(
    input  logic        CLK,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_done,
    output logic [31:0] word
);

    logic [BYTE_IDX_W-1:0] byte_cnt;
    logic [23:0]           shift_reg;

    assign word_done = byte_valid && (byte_cnt == BYTE_IDX_W'(BYTES_PER_WORD - 1));
    assign word      = {shift_reg, byte_data};

    // A clear in the same cycle as the final byte still lets that word out.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            byte_cnt  <= '0;
            shift_reg <= '0;
        end else if (clear) begin
            byte_cnt  <= '0;
            shift_reg <= '0;
        end else if (byte_valid) begin
            byte_cnt  <= byte_cnt + BYTE_IDX_W'(1);
            shift_reg <= {shift_reg[15:0], byte_data};
        end
    end

endmodule

// File: rtl/cpu_io_sequencer.sv
// Program load from UART into instruction memory, then run-time UART word
// input/output for in/out instructions with pipeline stall generation.
module cpu_io_sequencer
    import cpu_pkg::*;
#(
    parameter int INST_MEM_WIDTH = 2
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      start_sw,
    input  logic                      end_sw,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic                      imem_we,
    output logic [INST_MEM_WIDTH-1:0] imem_addr,
    output logic [31:0]               imem_wdata,
    output logic                      cpu_run,
    input  logic                      cpu_in_req,
    output logic [31:0]               cpu_in_data,
    input  logic                      cpu_out_req,
    input  logic [31:0]               cpu_out_data,
    output logic [7:0]                tx_data,
    output logic                      tx_enable,
    input  logic                      tx_ready,
    output logic                      stall,
    output logic [3:0]                led
);

    mode_t                 mode, mode_next;
    out_state_t            out_state, out_state_next;
    logic                  run_mode, load_mode;
    logic                  load_clear, run_clear;
    logic                  load_done, in_done;
    logic [31:0]           load_word, in_word;
    logic                  in_full, rx_overflow, in_consume;
    logic [31:0]           in_hold, out_word;
    logic [BYTE_IDX_W-1:0] out_idx;
    logic                  out_busy, out_accept;

    assign run_mode   = (mode == RUN);
    assign load_mode  = (mode == LOAD);
    assign load_clear = ((mode == IDLE) && start_sw) || (load_mode && end_sw);
    assign run_clear  = load_mode && end_sw;

    always_comb begin
        mode_next = mode;
        case (mode)
            IDLE:    if (start_sw) mode_next = LOAD;
            LOAD:    if (end_sw)   mode_next = RUN;
            default: mode_next = mode;
        endcase
    end

    word_assembler u_load_asm (
        .CLK        (CLK),
        .reset      (reset),
        .clear      (load_clear),
        .byte_valid (rx_valid && load_mode),
        .byte_data  (rx_data),
        .word_done  (load_done),
        .word       (load_word)
    );

    word_assembler u_in_asm (
        .CLK        (CLK),
        .reset      (reset),
        .clear      (run_clear),
        .byte_valid (rx_valid && run_mode),
        .byte_data  (rx_data),
        .word_done  (in_done),
        .word       (in_word)
    );

    // Write strobe lags the fourth byte by one cycle; the address advances after it.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            mode       <= IDLE;
            cpu_run    <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            mode    <= mode_next;
            cpu_run <= (mode_next == RUN);
            imem_we <= load_done;
            if (load_done)
                imem_wdata <= load_word;
            if ((mode == IDLE) && start_sw)
                imem_addr <= '0;
            else if (imem_we)
                imem_addr <= imem_addr + INST_MEM_WIDTH'(1);
        end
    end

    assign in_consume  = run_mode && cpu_in_req && in_full;
    assign cpu_in_data = in_hold;

    // A word completing alongside a consume refills the holding register.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            in_full     <= 1'b0;
            in_hold     <= '0;
            rx_overflow <= 1'b0;
        end else if (in_done) begin
            if (!in_full || in_consume) begin
                in_hold <= in_word;
                in_full <= 1'b1;
            end else begin
                rx_overflow <= 1'b1;
            end
        end else if (in_consume) begin
            in_full <= 1'b0;
        end
    end

    assign out_busy   = (out_state != O_IDLE);
    assign out_accept = run_mode && cpu_out_req && !out_busy;

    always_comb begin
        out_state_next = out_state;
        tx_enable      = 1'b0;
        tx_data        = 8'h00;
        case (out_state)
            O_IDLE: if (out_accept) out_state_next = O_SEND;
            O_SEND: begin
                if (tx_ready) begin
                    tx_enable      = 1'b1;
                    tx_data        = word_byte(out_word, out_idx);
                    out_state_next = O_GUARD;
                end
            end
            O_GUARD: begin
                if (out_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1))
                    out_state_next = O_IDLE;
                else
                    out_state_next = O_SEND;
            end
            default: out_state_next = O_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            out_state <= O_IDLE;
            out_word  <= '0;
            out_idx   <= '0;
        end else begin
            out_state <= out_state_next;
            if (out_accept) begin
                out_word <= cpu_out_data;
                out_idx  <= '0;
            end else if (out_state == O_GUARD) begin
                out_idx <= out_idx + BYTE_IDX_W'(1);
            end
        end
    end

    assign stall = run_mode && ((cpu_in_req && !in_full) || (cpu_out_req && out_busy));
    assign led   = {out_busy, rx_overflow, run_mode, load_mode};

endmodule

// File: tb/tb_cpu_io_sequencer.sv
// Directed-plus-random bench for cpu_io_sequencer with a word-level reference
// model of the load, input and output paths.
module tb_cpu_io_sequencer;

    localparam int IMW = 2;

    logic           CLK = 1'b0;
    logic           reset = 1'b0;
    logic           start_sw = 1'b0, end_sw = 1'b0;
    logic [7:0]     rx_data = 8'h00;
    logic           rx_valid = 1'b0;
    logic           imem_we;
    logic [IMW-1:0] imem_addr;
    logic [31:0]    imem_wdata;
    logic           cpu_run;
    logic           cpu_in_req = 1'b0;
    logic [31:0]    cpu_in_data;
    logic           cpu_out_req = 1'b0;
    logic [31:0]    cpu_out_data = 32'h0;
    logic [7:0]     tx_data;
    logic           tx_enable;
    logic           tx_ready = 1'b0;
    logic           stall;
    logic [3:0]     led;

    cpu_io_sequencer #(.INST_MEM_WIDTH(IMW)) dut (
        .CLK(CLK), .reset(reset), .start_sw(start_sw), .end_sw(end_sw),
        .rx_data(rx_data), .rx_valid(rx_valid), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_run(cpu_run),
        .cpu_in_req(cpu_in_req), .cpu_in_data(cpu_in_data),
        .cpu_out_req(cpu_out_req), .cpu_out_data(cpu_out_data),
        .tx_data(tx_data), .tx_enable(tx_enable), .tx_ready(tx_ready),
        .stall(stall), .led(led)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [IMW+31:0] wr_q[$];
    logic [7:0]      tx_q[$];
    int              tx_cyc_q[$];

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (imem_we) wr_q.push_back({imem_addr, imem_wdata});
        if (tx_enable) begin
            tx_q.push_back(tx_data);
            tx_cyc_q.push_back(cyc);
        end
    end

    // Input-path reference: one holding slot, sticky overflow.
    logic        m_full = 1'b0, m_ovf = 1'b0;
    logic [31:0] m_hold = 32'h0;

    task automatic m_word(input logic [31:0] w);
        if (m_full) m_ovf = 1'b1;
        else begin m_hold = w; m_full = 1'b1; end
    endtask

    task automatic m_consume();
        m_full = 1'b0;
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
        return 8'(w >> (8 * (3 - k)));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(byte_of(w, k));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_imem_we"},   imem_we, 0);
        check({tag, "_imem_addr"}, imem_addr, 0);
        check({tag, "_imem_wdata"}, imem_wdata, 0);
        check({tag, "_cpu_run"},   cpu_run, 0);
        check({tag, "_tx_enable"}, tx_enable, 0);
        check({tag, "_tx_data"},   tx_data, 0);
        check({tag, "_led"},       led, 0);
        check({tag, "_in_data"},   cpu_in_data, 0);
        check({tag, "_stall"},     stall, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] words[5];
        logic [31:0] a, b, c, d, w2;
        int          n, budget;

        // Reset with requests and ready asserted: everything must still read 0.
        cpu_in_req = 1'b1;
        tx_ready   = 1'b1;
        repeat (3) tick();
        #1 check_all_zero("reset");
        reset      = 1'b1;
        cpu_in_req = 1'b0;
        tx_ready   = 1'b0;
        tick();

        // IDLE ignores bytes and end_sw.
        end_sw = 1'b1;
        send_word(32'hCAFEF00D);
        end_sw = 1'b0;
        tick();
        check("idle_no_write", wr_q.size(), 0);
        check("idle_led", led, 4'b0000);

        start_sw = 1'b1;
        tick();
        start_sw = 1'b0;
        #1 check("load_led", led, 4'b0001);
        check("load_cpu_run", cpu_run, 0);

        words[0] = 32'h12345678;
        words[1] = 32'h9ABCDEF0;
        for (int i = 2; i < 5; i++) words[i] = $urandom;
        for (int i = 0; i < 4; i++) send_word(words[i]);
        for (int k = 0; k < 3; k++) send_byte(byte_of(words[4], k));
        // Final byte coincides with end_sw: written, then RUN.
        rx_data  = byte_of(words[4], 3);
        rx_valid = 1'b1;
        end_sw   = 1'b1;
        tick();
        rx_valid = 1'b0;
        end_sw   = 1'b0;
        #1 check("exit_imem_we", imem_we, 1);
        check("exit_wrap_addr", imem_addr, 0);
        check("exit_cpu_run", cpu_run, 1);
        tick();
        tick();
        check("load_count", wr_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < wr_q.size()) begin
                check($sformatf("load_addr%0d", i), 32'(wr_q[i][IMW+31:32]), 32'(i % (1 << IMW)));
                check($sformatf("load_data%0d", i), wr_q[i][31:0], words[i]);
            end
        end
        check("run_led", led, 4'b0010);

        // Input stall until a full word is present.
        cpu_in_req = 1'b1;
        #1 check("in_stall_empty", stall, !m_full);
        for (int k = 0; k < 3; k++) send_byte(8'h00);
        #1 check("in_stall_partial", stall, 1);
        send_byte(8'h2A);
        m_word(32'h0000002A);
        #1 check("in_stall_release", stall, 0);
        check("in_data_2a", cpu_in_data, m_hold);
        tick();
        m_consume();
        #1 check("in_after_consume", stall, !m_full);
        cpu_in_req = 1'b0;

        // Overflow: second word dropped, first kept.
        a = $urandom;
        b = $urandom;
        send_word(a); m_word(a);
        send_word(b); m_word(b);
        tick();
        check("ovf_led2", led[2], m_ovf);
        cpu_in_req = 1'b1;
        #1 check("ovf_stall", stall, 0);
        check("ovf_kept_first", cpu_in_data, m_hold);
        tick();
        m_consume();
        cpu_in_req = 1'b0;

        // Completion in the same cycle as a consume replaces the held word.
        c = $urandom;
        d = $urandom;
        send_word(c); m_word(c);
        for (int k = 0; k < 3; k++) send_byte(byte_of(d, k));
        cpu_in_req = 1'b1;
        send_byte(byte_of(d, 3));
        m_consume(); m_word(d);
        #1 check("swap_stall", stall, !m_full);
        check("swap_data", cpu_in_data, m_hold);
        tick();
        m_consume();
        cpu_in_req = 1'b0;

        // Random words with random inter-byte gaps.
        for (int it = 0; it < 4; it++) begin
            a = $urandom;
            for (int k = 0; k < 4; k++) begin
                send_byte(byte_of(a, k));
                repeat ($urandom_range(0, 2)) tick();
            end
            m_word(a);
            cpu_in_req = 1'b1;
            #1 check($sformatf("rand_in_stall%0d", it), stall, !m_full);
            check($sformatf("rand_in_data%0d", it), cpu_in_data, m_hold);
            tick();
            m_consume();
            cpu_in_req = 1'b0;
        end

        // Output: accepted without stall, then busy for 2 cycles per byte.
        tx_ready     = 1'b1;
        cpu_out_data = 32'hDEADBEEF;
        cpu_out_req  = 1'b1;
        #1 check("out_accept_stall", stall, 0);
        tick();
        w2 = $urandom;
        cpu_out_data = w2;
        for (int i = 0; i < 2 * 4; i++) begin
            #1 check($sformatf("out_busy_stall%0d", i), stall, 1);
            tick();
        end
        #1 check("out_second_accept", stall, 0);
        check("out_byte_count", tx_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < tx_q.size())
                check($sformatf("out_byte%0d", i), tx_q[i], byte_of(32'hDEADBEEF, i));
        for (int i = 1; i < 4; i++)
            if (i < tx_cyc_q.size())
                check($sformatf("out_gap%0d", i), (tx_cyc_q[i] - tx_cyc_q[i-1]) >= 2, 1);
        tick();
        cpu_out_req = 1'b0;

        // Second word under random tx_ready; reset after two bytes.
        budget = 0;
        while (tx_q.size() < 6 && budget < 200) begin
            tx_ready = 1'($urandom_range(0, 1));
            tick();
            budget++;
        end
        check("out2_reached_two", tx_q.size(), 6);
        for (int i = 4; i < 6; i++)
            if (i < tx_q.size())
                check($sformatf("out2_byte%0d", i - 4), tx_q[i], byte_of(w2, i - 4));
        tx_ready    = 1'b1;
        cpu_in_req  = 1'b1;
        cpu_out_req = 1'b1;
        reset       = 1'b0;
        #1 check_all_zero("midsend_reset");
        n = tx_q.size();
        tick();
        tick();
        reset = 1'b1;
        repeat (10) tick();
        check("post_reset_no_tx", tx_q.size(), n);
        check("post_reset_led", led, 4'b0000);
        check("post_reset_stall", stall, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
